ram_resp: RTL and testbench
===========================

RAM_RESP -- requirements
Module: ram_resp

Interface
REQ-001: The block SHALL have parameter SIZE, default 4096, meaning the number of 32-bit words in backing storage, which must be a power of two.
REQ-002: The block SHALL have parameter ADDR_W, default 12, meaning log2(SIZE).
REQ-003: The block SHALL have parameter LATENCY, default 4, meaning request-to-completion cycles, with a legal range of 1..255.
REQ-004: The block SHALL have port clk, input, width 1, the single clock; all logic is on the rising edge.
REQ-005: The block SHALL have port rst_n, input, width 1, an asynchronous active-low reset.
REQ-006: The block SHALL have port data, input, width 32, the write data.
REQ-007: The block SHALL have port address, input, width 32, the word address; only bits [ADDR_W-1:0] are used (address mod SIZE).
REQ-008: The block SHALL have port mode, input, width 1, where 1 is write and 0 is read.
REQ-009: The block SHALL have port out, output, width 32, the read data, held until the next read completes.
REQ-010: The block SHALL have port response, output, width 1, where 1 is busy and 0 is idle/complete.

Function
REQ-011: The block SHALL hold latched registers lat_addr[ADDR_W-1:0], lat_data[31:0] and lat_mode, plus a memory array mem[SIZE-1:0][31:0].
REQ-012: The block SHALL have FSM states IDLE and BUSY only.
REQ-013: In IDLE, a request SHALL be detected at a rising edge when address[ADDR_W-1:0] != lat_addr, or data != lat_data, or mode != lat_mode.
REQ-014: On detection, the block SHALL latch all three inputs, load the counter with LATENCY-1, set response=1, and enter BUSY, all at that same edge.
REQ-015: In BUSY, input changes SHALL be ignored; only the latched values are used.
REQ-016: In BUSY with counter != 0, the block SHALL decrement the counter each edge.
REQ-017: In BUSY with counter == 0, at that edge the block SHALL perform the operation, set response=0, and return to IDLE.
REQ-018: The read operation SHALL be out <= mem[lat_addr].
REQ-019: The write operation SHALL be mem[lat_addr] <= lat_data, with out unchanged.
REQ-020: Response SHALL therefore be high for exactly LATENCY cycles per request; for LATENCY=1, response is high for one cycle.
REQ-021: Re-detection after completion SHALL compare against the latched values, so unchanged inputs do not retrigger and the next request needs at least one differing field.
REQ-022: Inputs differing at the completion edge SHALL NOT start a request at that edge; they are detected at the following edge in IDLE.
REQ-023: A read of a never-written location SHALL return 0, because mem is zero-initialised at simulation start.
REQ-024: Address wrap SHALL occur so that address SIZE+k maps to word k; upper address bits SHALL NOT take part in change detection.

Reset
REQ-025: While rst_n=0, the block SHALL force state=IDLE, counter=0, response=0, out=0, lat_addr=0, lat_data=0 and lat_mode=0.
REQ-026: Reset SHALL NOT clear the contents of mem.
REQ-027: Reset asserted during BUSY SHALL abort the request; a pending write SHALL NOT reach mem.
REQ-028: After reset release, inputs equal to address=0, data=0, mode=0 SHALL NOT form a request.

Configuration
REQ-029: With macro RAM_RESP_STATS_EN defined, the block SHALL add output ports rd_count[15:0] and wr_count[15:0].
REQ-030: When RAM_RESP_STATS_EN is defined, rd_count and wr_count SHALL increment at each completed read or write respectively, saturate at 16'hFFFF, and reset to 0.
REQ-031: Without RAM_RESP_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification (LATENCY=4 unless stated)
REQ-032: Reset, then drive address=5, data=32'hA5A5A5A5, mode=1, held -> response=1 for exactly 4 cycles, then 0; out stays 0.
REQ-033: After REQ-032, drive mode=0 with address=5 -> response high 4 cycles, then out=32'hA5A5A5A5; holding inputs thereafter produces no further response pulse.
REQ-034: Write data=32'h1234 to address 4096+7, then read address 7 -> out=32'h00001234.
REQ-035: Change address during BUSY from 9 to 10 -> the completed operation uses address 9; one cycle after returning to IDLE a new request for address 10 starts.
REQ-036: Start a write of 32'hDEAD to address 3, assert rst_n=0 at cycle 2 of BUSY, release, then read address 3 -> out=0, and response=0 immediately upon reset assertion.
REQ-037: With RAM_RESP_STATS_EN and LATENCY=1, perform 3 writes and 2 reads -> wr_count=3, rd_count=2, and each response pulse is 1 cycle wide.

Source files
------------

// File: rtl/ram_resp.sv
// Latency-modelled single-port RAM responder: a change on the request inputs starts a
// LATENCY-cycle busy window, after which the read or write completes. Optional
// read/write statistics counters are enabled with macro RAM_RESP_STATS_EN.
module ram_resp #(
  parameter int unsigned SIZE    = 4096,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [31:0] address,
  input  logic        mode,
  output logic [31:0] out,
  output logic        response
`ifdef RAM_RESP_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_lat_addr, w_lat_addr_nxt;
  logic [31:0]       r_lat_data, w_lat_data_nxt;
  logic              r_lat_mode, w_lat_mode_nxt;
  logic              r_resp, w_resp_nxt;
  logic [31:0]       r_out;
  // No reset on storage: contents survive rst_n and power up zero in simulation.
  logic [31:0]       r_mem [SIZE];

  logic [ADDR_W-1:0] w_addr;
  logic              w_req;
  logic              w_done;
  logic              w_rd_done;
  logic              w_wr_done;
  logic              w_unused_addr;

  assign w_addr        = address[ADDR_W-1:0];
  assign w_unused_addr = ^address[31:ADDR_W];

  // A request is any difference from the last latched transaction.
  assign w_req = (w_addr != r_lat_addr) || (data != r_lat_data) || (mode != r_lat_mode);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_lat_addr_nxt = r_lat_addr;
    w_lat_data_nxt = r_lat_data;
    w_lat_mode_nxt = r_lat_mode;
    w_resp_nxt     = r_resp;
    w_done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_lat_addr_nxt = w_addr;
          w_lat_data_nxt = data;
          w_lat_mode_nxt = mode;
          w_cnt_nxt      = 8'(LATENCY - 1);
          w_resp_nxt     = 1'b1;
          w_state_nxt    = StBusy;
        end
      end
      StBusy: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_done      = 1'b1;
          w_resp_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_rd_done = w_done & ~r_lat_mode;
  assign w_wr_done = w_done & r_lat_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= 8'd0;
      r_lat_addr <= '0;
      r_lat_data <= 32'd0;
      r_lat_mode <= 1'b0;
      r_resp     <= 1'b0;
      r_out      <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lat_addr <= w_lat_addr_nxt;
      r_lat_data <= w_lat_data_nxt;
      r_lat_mode <= w_lat_mode_nxt;
      r_resp     <= w_resp_nxt;
      if (w_rd_done) begin
        r_out <= r_mem[r_lat_addr];
      end
    end
  end

  // State is forced idle asynchronously, so an aborted write never reaches storage.
  always_ff @(posedge clk) begin
    if (w_wr_done) begin
      r_mem[r_lat_addr] <= r_lat_data;
    end
  end

  assign out      = r_out;
  assign response = r_resp;

`ifdef RAM_RESP_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else begin
      if (w_rd_done && (r_rd_count != 16'hFFFF)) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
      if (w_wr_done && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_ram_resp.sv
// Directed bench for ram_resp: table of request vectors on a LATENCY=4 instance plus
// hand sequences for busy-time input changes, reset abort and a LATENCY=1 instance.
module tb_ram_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst1_n;
  logic [31:0] data;
  logic [31:0] address;
  logic        mode;
  logic [31:0] out0, out1;
  logic        resp0, resp1;
`ifdef RAM_RESP_STATS_EN
  logic [15:0] unused_rd0, unused_wr0, rd1, wr1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_resp #(.SIZE(4096), .ADDR_W(12), .LATENCY(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .address  (address),
    .mode     (mode),
    .out      (out0),
    .response (resp0)
`ifdef RAM_RESP_STATS_EN
    ,
    .rd_count (unused_rd0),
    .wr_count (unused_wr0)
`endif
  );

  ram_resp #(.SIZE(4096), .ADDR_W(12), .LATENCY(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst1_n),
    .data     (data),
    .address  (address),
    .mode     (mode),
    .out      (out1),
    .response (resp1)
`ifdef RAM_RESP_STATS_EN
    ,
    .rd_count (rd1),
    .wr_count (wr1)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int          len;
    logic [31:0] exp_out;
  } vec_t;

  vec_t tbl[11];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, watch a fixed window, then check pulse width and read data.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic m,
                         input bit sel, input int win, input int exp_len,
                         input logic [31:0] exp_out, input string name);
    int hi;
    hi      = 0;
    address = a;
    data    = d;
    mode    = m;
    for (int i = 0; i < win; i++) begin
      cycle();
      if ((sel ? resp1 : resp0) === 1'b1) hi++;
    end
    check({name, " pulse"}, 32'(hi), 32'(exp_len));
    check({name, " out"}, sel ? out1 : out0, exp_out);
  endtask

  initial begin
    tbl[0]  = '{32'd0,          32'h0,         1'b0, 0, 32'h0};
    tbl[1]  = '{32'd5,          32'hA5A5A5A5,  1'b1, 4, 32'h0};
    tbl[2]  = '{32'd5,          32'hA5A5A5A5,  1'b0, 4, 32'hA5A5A5A5};
    tbl[3]  = '{32'd5,          32'hA5A5A5A5,  1'b0, 0, 32'hA5A5A5A5};
    tbl[4]  = '{32'd4103,       32'h00001234,  1'b1, 4, 32'hA5A5A5A5};
    tbl[5]  = '{32'd7,          32'h00001234,  1'b0, 4, 32'h00001234};
    tbl[6]  = '{32'd100,        32'h0,         1'b0, 4, 32'h0};
    tbl[7]  = '{32'd4196,       32'h0,         1'b0, 0, 32'h0};
    tbl[8]  = '{32'd7,          32'hFFFF0000,  1'b0, 4, 32'h00001234};
    tbl[9]  = '{32'h00000FFF,   32'hCAFEF00D,  1'b1, 4, 32'h00001234};
    tbl[10] = '{32'hFFFFFFFF,   32'hCAFEF00D,  1'b0, 4, 32'hCAFEF00D};

    rst_n   = 1'b0;
    rst1_n  = 1'b0;
    address = 32'd0;
    data    = 32'd0;
    mode    = 1'b0;
    cycle();
    cycle();
    check("reset response", {31'd0, resp0}, 32'd0);
    check("reset out", out0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 11; i++) begin
      run_req(tbl[i].addr, tbl[i].wdata, tbl[i].wr, 1'b0, 8, tbl[i].len, tbl[i].exp_out,
              $sformatf("vec%0d", i));
    end

    // Address changes while busy: write must land at 9, then 10 starts one idle cycle later.
    address = 32'd9;
    data    = 32'h00000099;
    mode    = 1'b1;
    cycle();
    check("busy start", {31'd0, resp0}, 32'd1);
    address = 32'd10;
    cycle();
    cycle();
    cycle();
    check("busy held", {31'd0, resp0}, 32'd1);
    cycle();
    check("idle gap", {31'd0, resp0}, 32'd0);
    cycle();
    check("second start", {31'd0, resp0}, 32'd1);
    for (int i = 0; i < 5; i++) cycle();
    check("second done", {31'd0, resp0}, 32'd0);
    run_req(32'd9, 32'h0, 1'b0, 1'b0, 8, 4, 32'h00000099, "read9");
    run_req(32'd10, 32'h0, 1'b0, 1'b0, 8, 4, 32'h00000099, "read10");

    // Reset in the second busy cycle aborts the write to address 3.
    address = 32'd3;
    data    = 32'h0000DEAD;
    mode    = 1'b1;
    cycle();
    check("abort busy", {31'd0, resp0}, 32'd1);
    cycle();
    rst_n = 1'b0;
    #1;
    check("abort response", {31'd0, resp0}, 32'd0);
    check("abort out", out0, 32'd0);
    data = 32'd0;
    mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_req(32'd3, 32'h0, 1'b0, 1'b0, 8, 4, 32'h0, "read3 after abort");

    // LATENCY=1 instance: single-cycle pulses and statistics.
    address = 32'd0;
    data    = 32'd0;
    mode    = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    cycle();
    run_req(32'd1, 32'd11, 1'b1, 1'b1, 4, 1, 32'd0, "l1 wr1");
    run_req(32'd2, 32'd22, 1'b1, 1'b1, 4, 1, 32'd0, "l1 wr2");
    run_req(32'd3, 32'd33, 1'b1, 1'b1, 4, 1, 32'd0, "l1 wr3");
    run_req(32'd1, 32'd0, 1'b0, 1'b1, 4, 1, 32'd11, "l1 rd1");
    run_req(32'd3, 32'd0, 1'b0, 1'b1, 4, 1, 32'd33, "l1 rd3");
`ifdef RAM_RESP_STATS_EN
    check("wr_count", {16'd0, wr1}, 32'd3);
    check("rd_count", {16'd0, rd1}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
